regfile_fwd_sb: RTL and testbench
=================================

Name: regfile_fwd_sb

Overview:
- Parametrised successor to the controller's register file: NREG x (FLAG_W+DATA_W) storage, one write port, two registered read ports.
- Write-to-read forwarding on both read ports, covering data and flags.
- Adds write enable, read enable/valid, optional hardwired zero register and an optional pending-write scoreboard.
- Sits between decode (read stage) and writeback in the four-stage pipeline.

Parameters:
- DATA_W, 32, data width per register
- FLAG_W, 3, flag bits stored alongside each register
- ADDR_W, 4, address width; NREG = 2**ADDR_W
- R0_ZERO, 1, 1: register 0 always reads zero data/flags and ignores writes; 0: register 0 is ordinary

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- rd_en  in  1  capture read operands this cycle
- s1_addr  in  ADDR_W  source 1 address
- s2_addr  in  ADDR_W  source 2 address
- s1_data  out  DATA_W  registered source 1 data
- s2_data  out  DATA_W  registered source 2 data
- s1_flags  out  FLAG_W  registered source 1 flags
- s2_flags  out  FLAG_W  registered source 2 flags
- rd_valid  out  1  high one cycle after an accepted rd_en
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  destination address
- wr_data  in  DATA_W  write data
- wr_flags  in  FLAG_W  write flags
- issue_en  in  1  instruction issued that will write issue_dest
- issue_dest  in  ADDR_W  destination being reserved
- s1_busy  out  1  registered: s1 operand was pending at capture
- s2_busy  out  1  registered: s2 operand was pending at capture

Behaviour:
- Reset: sampled on clk only. While reset_n=0 at an edge, all outputs go to 0, all storage entries go to 0, all busy bits go to 0, and writes/issues in that cycle are discarded. Reset has priority over every other event.
- Write: at an edge with wr_en=1, {wr_flags,wr_data} is stored in entry wr_addr. With R0_ZERO=1 and wr_addr=0, the write is dropped.
- Read: latency is 1 cycle. At an edge with rd_en=1, each sN output loads the value at sN_addr, and rd_valid is 1 in the following cycle.
- rd_en=0: rd_valid goes to 0 and the data/flags/busy outputs hold their previous values.
- Forwarding: if wr_en=1 and wr_addr==sN_addr in the same cycle as rd_en, sN_data/sN_flags take wr_data/wr_flags rather than the stale entry. This applies independently per port, and both ports forward when both match.
- R0_ZERO=1 and sN_addr=0: sN_data/sN_flags are 0 regardless of any forwarding match.
- s1_addr==s2_addr: both ports return identical values.
- No read-during-write ambiguity: a read in the cycle after the write returns the new value from storage.

Optional Feature:
- Macro RF_SCOREBOARD_EN.
- With the macro defined: a busy vector holds NREG bits.
  - issue_en sets busy[issue_dest]; wr_en clears busy[wr_addr].
  - Same-cycle issue and write to the same address: set wins (the new producer is pending).
  - With R0_ZERO=1, busy[0] is never set.
  - On rd_en, sN_busy captures busy[sN_addr] AND NOT (wr_en AND wr_addr==sN_addr); a same-cycle writeback satisfies the operand.
  - Reissuing an already-busy register keeps it busy.
- Without the macro: no busy vector, s1_busy/s2_busy are constant 0, and issue_en/issue_dest are ignored.

Test Plan:
- Reset then read: reset_n=0 for 2 clks, rd_en with s1=5, s2=9 -> next cycle s1_data=0, s2_data=0, flags=0, rd_valid=1.
- Write/read: wr r3=0xDEADBEEF flags=3'b101; read s1=3 one cycle later -> s1_data=0xDEADBEEF, s1_flags=3'b101.
- Forwarding: r7 holds 0x11; same cycle wr r7=0x22 and rd s1=7, s2=7 -> both outputs 0x22; next read of r7 returns 0x22.
- Zero register (R0_ZERO=1): wr r0=0xFFFFFFFF, then the same cycle wr r0=0x5 with rd s1=0 -> s1_data=0, s1_flags=0.
- Scoreboard (macro on):
  - issue r4; read s1=4 -> s1_busy=1.
  - wr r4 with rd s1=4 in the same cycle -> s1_busy=0 and data forwarded.
  - issue+wr r6 in the same cycle, then read s2=6 -> s2_busy=1.
- Reset mid-operation: busy r2 set, rd_valid=1, then reset_n=0 for 1 clk with wr_en=1 on r2 -> outputs 0, r2 reads 0, s1_busy=0 afterwards.

Source files
------------

// File: rtl/regfile_fwd_sb.sv
// Register file with data+flags per entry, one write port and two registered
// read ports with write-to-read forwarding. Register 0 can be hardwired to zero.
// Optional pending-write scoreboard, enabled by defining RF_SCOREBOARD_EN.
module regfile_fwd_sb #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FLAG_W  = 3,
  parameter int unsigned ADDR_W  = 4,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [ADDR_W-1:0] s2_addr,
  output logic [DATA_W-1:0] s1_data,
  output logic [DATA_W-1:0] s2_data,
  output logic [FLAG_W-1:0] s1_flags,
  output logic [FLAG_W-1:0] s2_flags,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [FLAG_W-1:0] wr_flags,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              s1_busy,
  output logic              s2_busy
);

  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam int unsigned ENT_W = FLAG_W + DATA_W;

  logic [ENT_W-1:0] mem [NREG];
  logic             wr_ok_c;
  logic             s1_hit_c;
  logic             s2_hit_c;
  logic [ENT_W-1:0] s1_ent_c;
  logic [ENT_W-1:0] s2_ent_c;

  // A write to the hardwired zero register is dropped
  assign wr_ok_c  = wr_en && !(R0_ZERO && (wr_addr == ADDR_W'(0)));
  assign s1_hit_c = wr_en && (wr_addr == s1_addr);
  assign s2_hit_c = wr_en && (wr_addr == s2_addr);

  // Operand selection: forward the in-flight write, zero register overrides all
  always_comb begin
    s1_ent_c = mem[s1_addr];
    s2_ent_c = mem[s2_addr];
    if (s1_hit_c) s1_ent_c = {wr_flags, wr_data};
    if (s2_hit_c) s2_ent_c = {wr_flags, wr_data};
    if (R0_ZERO && (s1_addr == ADDR_W'(0))) s1_ent_c = '0;
    if (R0_ZERO && (s2_addr == ADDR_W'(0))) s2_ent_c = '0;
  end

  // Storage array update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_ok_c) begin
      mem[wr_addr] <= {wr_flags, wr_data};
    end
  end

  // Registered read ports; operands hold while rd_en is low
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_data  <= '0;
      s2_data  <= '0;
      s1_flags <= '0;
      s2_flags <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        s1_data  <= s1_ent_c[DATA_W-1:0];
        s1_flags <= s1_ent_c[ENT_W-1:DATA_W];
        s2_data  <= s2_ent_c[DATA_W-1:0];
        s2_flags <= s2_ent_c[ENT_W-1:DATA_W];
      end
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt_c;

  // Pending-write tracking: writeback clears, issue sets, and set wins on collision
  always_comb begin
    busy_nxt_c = busy;
    if (wr_en) busy_nxt_c[wr_addr] = 1'b0;
    if (issue_en && !(R0_ZERO && (issue_dest == ADDR_W'(0)))) busy_nxt_c[issue_dest] = 1'b1;
  end

  // Busy vector and captured operand busy flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy    <= '0;
      s1_busy <= 1'b0;
      s2_busy <= 1'b0;
    end else begin
      busy <= busy_nxt_c;
      if (rd_en) begin
        s1_busy <= busy[s1_addr] && !s1_hit_c;
        s2_busy <= busy[s2_addr] && !s2_hit_c;
      end
    end
  end
`else
  logic unused_issue_c;

  // Scoreboard absent: operands are never reported pending
  assign s1_busy        = 1'b0;
  assign s2_busy        = 1'b0;
  assign unused_issue_c = ^{issue_en, issue_dest};
`endif

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Directed table-driven bench for regfile_fwd_sb (default parameters).
module tb_regfile_fwd_sb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_en;
  logic [3:0]  s1_addr, s2_addr;
  logic [31:0] s1_data, s2_data;
  logic [2:0]  s1_flags, s2_flags;
  logic        rd_valid;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  wr_flags;
  logic        issue_en;
  logic [3:0]  issue_dest;
  logic        s1_busy, s2_busy;

  int checks   = 0;
  int failures = 0;

  regfile_fwd_sb dut (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en),
    .s1_addr(s1_addr), .s2_addr(s2_addr),
    .s1_data(s1_data), .s2_data(s2_data),
    .s1_flags(s1_flags), .s2_flags(s2_flags),
    .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_flags(wr_flags),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .s1_busy(s1_busy), .s2_busy(s2_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rd;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [2:0]  wf;
    logic        iss;
    logic [3:0]  idst;
    logic [31:0] e1d;
    logic [2:0]  e1f;
    logic [31:0] e2d;
    logic [2:0]  e2f;
    logic        ev;
    logic        eb1;
    logic        eb2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic rd, logic [3:0] s1, logic [3:0] s2,
                              logic we, logic [3:0] wa, logic [31:0] wd, logic [2:0] wf,
                              logic iss, logic [3:0] idst,
                              logic [31:0] e1d, logic [2:0] e1f,
                              logic [31:0] e2d, logic [2:0] e2f,
                              logic ev, logic eb1, logic eb2);
    vec_t v;
    v.rst_n = rst_n; v.rd = rd; v.s1 = s1; v.s2 = s2;
    v.we = we; v.wa = wa; v.wd = wd; v.wf = wf;
    v.iss = iss; v.idst = idst;
    v.e1d = e1d; v.e1f = e1f; v.e2d = e2d; v.e2f = e2f;
    v.ev = ev; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_n = v.rst_n; rd_en = v.rd; s1_addr = v.s1; s2_addr = v.s2;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; wr_flags = v.wf;
    issue_en = v.iss; issue_dest = v.idst;
  endtask

  // Busy expectations only hold when the scoreboard is built in
  function automatic logic sb(logic b);
`ifdef RF_SCOREBOARD_EN
    return b;
`else
    return b & 1'b0;
`endif
  endfunction

  logic [31:0] model_d [16];
  logic [2:0]  model_f [16];

  initial begin
    vec_t z;
    z = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(z);
    reset_n = 1'b0;

    //       rst rd s1 s2 we wa wd            wf   is id  e1d           e1f  e2d           e2f  ev b1 b2
    vecs.push_back(mk(0, 1, 5, 9, 1, 2, 32'h0BAD,     3'd7, 1, 2, 32'h0,        3'd0, 32'h0,        3'd0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        3'd0, 32'h0,        3'd0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 5, 9, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        3'd0, 32'h0,        3'd0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 3, 32'hDEADBEEF, 3'd5, 0, 0, 32'h0,        3'd0, 32'h0,        3'd0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 5, 0, 0, 32'h0,        3'd0, 0, 0, 32'hDEADBEEF, 3'd5, 32'h0,        3'd0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 7, 32'h11,       3'd1, 0, 0, 32'hDEADBEEF, 3'd5, 32'h0,        3'd0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 7, 7, 1, 7, 32'h22,       3'd2, 0, 0, 32'h22,       3'd2, 32'h22,       3'd2, 1, 0, 0));
    vecs.push_back(mk(1, 1, 7, 3, 0, 0, 32'h0,        3'd0, 0, 0, 32'h22,       3'd2, 32'hDEADBEEF, 3'd5, 1, 0, 0));
    vecs.push_back(mk(1, 1, 3, 7, 1, 0, 32'hFFFFFFFF, 3'd7, 0, 0, 32'hDEADBEEF, 3'd5, 32'h22,       3'd2, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h5,        3'd1, 0, 0, 32'h0,        3'd0, 32'h0,        3'd0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 3, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        3'd0, 32'hDEADBEEF, 3'd5, 1, 0, 0));
    vecs.push_back(mk(1, 1, 9, 7, 1, 9, 32'hA5A5,     3'd6, 0, 0, 32'hA5A5,     3'd6, 32'h22,       3'd2, 1, 0, 0));
    vecs.push_back(mk(1, 0, 9, 9, 1, 9, 32'h1,        3'd3, 0, 0, 32'hA5A5,     3'd6, 32'h22,       3'd2, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4, 3, 0, 0, 32'h0,        3'd0, 1, 4, 32'h0,        3'd0, 32'hDEADBEEF, 3'd5, 1, 0, 0));
    vecs.push_back(mk(1, 1, 4, 4, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        3'd0, 32'h0,        3'd0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 4, 9, 1, 4, 32'h44,       3'd4, 0, 0, 32'h44,       3'd4, 32'h1,        3'd3, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 6, 32'h66,       3'd1, 1, 6, 32'h44,       3'd4, 32'h1,        3'd3, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4, 6, 0, 0, 32'h0,        3'd0, 0, 0, 32'h44,       3'd4, 32'h66,       3'd1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 6, 6, 0, 0, 32'h0,        3'd0, 1, 6, 32'h66,       3'd1, 32'h66,       3'd1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 6, 0, 0, 32'h0,        3'd0, 1, 0, 32'h0,        3'd0, 32'h66,       3'd1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 2, 0, 0, 32'h0,        3'd0, 1, 2, 32'h0,        3'd0, 32'h0,        3'd0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 2, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        3'd0, 32'h0,        3'd0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 6, 2, 1, 2, 32'h0BAD,     3'd7, 1, 5, 32'h0,        3'd0, 32'h0,        3'd0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2, 6, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        3'd0, 32'h0,        3'd0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 5, 4, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        3'd0, 32'h0,        3'd0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check("s1_data",  i, s1_data,  vecs[i].e1d);
      check("s1_flags", i, 32'(s1_flags), 32'(vecs[i].e1f));
      check("s2_data",  i, s2_data,  vecs[i].e2d);
      check("s2_flags", i, 32'(s2_flags), 32'(vecs[i].e2f));
      check("rd_valid", i, 32'(rd_valid), 32'(vecs[i].ev));
      check("s1_busy",  i, 32'(s1_busy), 32'(sb(vecs[i].eb1)));
      check("s2_busy",  i, 32'(s2_busy), 32'(sb(vecs[i].eb2)));
    end

    // Fill every register, then read back pairs against a local model
    for (int i = 0; i < 16; i++) begin
      model_d[i] = 32'h0;
      model_f[i] = 3'd0;
    end
    for (int i = 0; i < 16; i++) begin
      drive(z);
      wr_en = 1'b1; wr_addr = 4'(i);
      wr_data = 32'h01010101 * 32'(i + 1); wr_flags = 3'(i + 1);
      if (i != 0) begin
        model_d[i] = wr_data;
        model_f[i] = wr_flags;
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 16; i++) begin
      drive(z);
      rd_en = 1'b1; s1_addr = 4'(i); s2_addr = 4'(15 - i);
      @(posedge clk);
      #1;
      check("bulk_s1_data",  100 + i, s1_data, model_d[i]);
      check("bulk_s1_flags", 100 + i, 32'(s1_flags), 32'(model_f[i]));
      check("bulk_s2_data",  100 + i, s2_data, model_d[15 - i]);
      check("bulk_s2_flags", 100 + i, 32'(s2_flags), 32'(model_f[15 - i]));
      check("bulk_rd_valid", 100 + i, 32'(rd_valid), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
